// File: rtl/card_pkg.sv
// Shared types for the card dealer: FSM states, reject codes and a width helper.
package card_pkg;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_ROUND_END = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REJ_NONE   = 2'b00,
        REJ_ONEHOT = 2'b01,
        REJ_USED   = 2'b10
    } rej_code_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Converts a one-hot vector to its bit index and flags whether exactly one bit is set.
module onehot_encoder #(
    parameter int N = 9,
    parameter int W = 4
) (
    input  logic [N-1:0] sel,
    output logic [W-1:0] idx,
    output logic         onehot_ok
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                idx = idx | W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign onehot_ok = (sel != '0) && ((sel & (sel - N'(1))) == '0);

endmodule

// File: rtl/card_dealer.sv
// Turn-based card handout: validates one-hot selections against the shared deck,
// records each player's card and sequences rounds through to game over.
module card_dealer
    import card_pkg::*;
#(
    parameter int NUM_CARDS    = 9,
    parameter int NUM_PLAYERS  = 2,
    parameter int RETURN_CARDS = 0,
    parameter int IDX_W        = clog2_min1(NUM_CARDS),
    parameter int PL_W         = clog2_min1(NUM_PLAYERS),
    parameter int RND_W        = $clog2(NUM_CARDS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_game,
    input  logic                         sel_valid,
    output logic                         sel_ready,
    input  logic [NUM_CARDS-1:0]         sel_card,
    output logic [PL_W-1:0]              turn,
    output logic [NUM_PLAYERS*IDX_W-1:0] hand_card,
    output logic [NUM_PLAYERS-1:0]       hand_valid,
    output logic [NUM_CARDS-1:0]         avail,
    output logic                         reject,
    output logic [1:0]                   reject_code,
    output logic                         round_done,
    input  logic                         round_ack,
    output logic [RND_W-1:0]             round_count,
    output logic                         game_over
);

    localparam logic [PL_W-1:0] LAST_TURN = PL_W'(NUM_PLAYERS - 1);

    state_t               state_reg, state_next;
    logic [PL_W-1:0]      turn_reg, turn_next;
    logic [NUM_CARDS-1:0] avail_reg, avail_next, avail_restore;
    logic                 reject_reg, reject_next;
    logic [1:0]           code_reg, code_next;
    logic [RND_W-1:0]     round_count_reg, round_count_next;
    logic [RND_W-1:0]     restore_count;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_onehot, card_free, accept, hand_load, hand_clear;

    onehot_encoder #(
        .N(NUM_CARDS),
        .W(IDX_W)
    ) u_encoder (
        .sel      (sel_card),
        .idx      (sel_idx),
        .onehot_ok(sel_onehot)
    );

    assign card_free     = |(sel_card & avail_reg);
    assign sel_ready     = (state_reg == ST_PLAY) & ~new_game;
    assign accept        = sel_valid & sel_ready;
    assign avail_restore = (RETURN_CARDS != 0) ? '1 : avail_reg;

    // Deck size as it will stand once the current round is acknowledged.
    always_comb begin
        restore_count = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            restore_count = restore_count + RND_W'(avail_restore[i]);
        end
    end

    always_comb begin
        state_next       = state_reg;
        turn_next        = turn_reg;
        avail_next       = avail_reg;
        reject_next      = 1'b0;
        code_next        = code_reg;
        round_count_next = round_count_reg;
        hand_load        = 1'b0;
        hand_clear       = 1'b0;
        if (new_game) begin
            state_next       = ST_PLAY;
            turn_next        = '0;
            avail_next       = '1;
            code_next        = REJ_NONE;
            round_count_next = '0;
        end else begin
            case (state_reg)
                ST_PLAY: begin
                    if (accept) begin
                        if (!sel_onehot) begin
                            reject_next = 1'b1;
                            code_next   = REJ_ONEHOT;
                        end else if (!card_free) begin
                            reject_next = 1'b1;
                            code_next   = REJ_USED;
                        end else begin
                            hand_load  = 1'b1;
                            avail_next = avail_reg & ~sel_card;
                            if (turn_reg == LAST_TURN) begin
                                state_next = ST_ROUND_END;
                            end else begin
                                turn_next = turn_reg + PL_W'(1);
                            end
                        end
                    end
                end
                ST_ROUND_END: begin
                    if (round_ack) begin
                        hand_clear = 1'b1;
                        turn_next  = '0;
                        avail_next = avail_restore;
                        if (round_count_reg != '1) begin
                            round_count_next = round_count_reg + RND_W'(1);
                        end
                        state_next = (int'(restore_count) < NUM_PLAYERS) ? ST_GAME_OVER : ST_PLAY;
                    end
                end
                ST_GAME_OVER: begin
                    state_next = ST_GAME_OVER;
                end
                default: begin
                    state_next = ST_PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_PLAY;
            turn_reg        <= '0;
            avail_reg       <= '1;
            reject_reg      <= 1'b0;
            code_reg        <= REJ_NONE;
            round_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            turn_reg        <= turn_next;
            avail_reg       <= avail_next;
            reject_reg      <= reject_next;
            code_reg        <= code_next;
            round_count_reg <= round_count_next;
        end
    end

    logic [IDX_W-1:0] hand_card_reg  [NUM_PLAYERS];
    logic             hand_valid_reg [NUM_PLAYERS];

    // One hand slot per player; hand_card keeps its value across round_ack.
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_hand
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hand_card_reg[gi]  <= '0;
                hand_valid_reg[gi] <= 1'b0;
            end else if (new_game) begin
                hand_card_reg[gi]  <= '0;
                hand_valid_reg[gi] <= 1'b0;
            end else if (hand_load && (turn_reg == PL_W'(gi))) begin
                hand_card_reg[gi]  <= sel_idx;
                hand_valid_reg[gi] <= 1'b1;
            end else if (hand_clear) begin
                hand_valid_reg[gi] <= 1'b0;
            end
        end
        assign hand_card[gi*IDX_W +: IDX_W] = hand_card_reg[gi];
        assign hand_valid[gi]               = hand_valid_reg[gi];
    end

    assign turn        = turn_reg;
    assign avail       = avail_reg;
    assign reject      = reject_reg;
    assign reject_code = code_reg;
    assign round_done  = (state_reg == ST_ROUND_END);
    assign round_count = round_count_reg;
    assign game_over   = (state_reg == ST_GAME_OVER);

endmodule
